// File: rtl/decoder_pkg.sv
// Shared types and constants for the pulse decoder family.
// Holds the FSM state encoding and the code/output widths.
package decoder_pkg;

    localparam int CODE_W = 2;
    localparam int OUT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Sizes the shared pulse/gap down-counter at elaboration time.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/onehot_dec2.sv
// Purely combinational 2-bit code to 4-bit one-hot decoder, no enable.
// Kept standalone so other decoders can reuse it.
module onehot_dec2
    import decoder_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [OUT_W-1:0]  onehot
);

    assign onehot = OUT_W'(1) << code;

endmodule

// File: rtl/decoder_pulse_2to4.sv
// Sequential 2-to-4 decoder: accepts a code over valid/ready and emits a
// registered one-hot pulse of PULSE_LEN cycles followed by GAP_LEN idle cycles.
module decoder_pulse_2to4
    import decoder_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CODE_W-1:0] in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(max_int(PULSE_LEN, GAP_LEN) + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;
    localparam bit HAS_GAP = (GAP_LEN > 0);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   dec_code;
    logic [OUT_W-1:0]    dec_onehot;

    assign in_ready = en && (state == IDLE);

    // In IDLE the decoder sees the incoming code so out is ready on the accept
    // edge; afterwards it sees only the latched code, so `in` cannot leak through.
    assign dec_code = (state == IDLE) ? in : code_q;

    onehot_dec2 u_dec (
        .code   (dec_code),
        .onehot (dec_onehot)
    );

    // NOTE: every register is reset here, including the code latch and counter,
    // so the block leaves reset in a fully defined state with no X on outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            code_q <= '0;
            out    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; done defaults low so it
            // can only ever be a single-cycle strobe.
            done <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                out   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            code_q <= in;
                            cnt    <= PULSE_LOAD;
                            out    <= dec_onehot;
                            busy   <= 1'b1;
                            state  <= PULSE;
                        end
                    end
                    PULSE: begin
                        if (cnt == '0) begin
                            out  <= '0;
                            done <= 1'b1;
                            if (HAS_GAP) begin
                                cnt   <= GAP_LOAD;
                                state <= GAP;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                            out <= dec_onehot;
                        end
                    end
                    GAP: begin
                        if (cnt == '0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        out   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
